// File: rtl/sum_isqrt_n_fsm.sv
// sum_isqrt_n_fsm
// ---------------
// Sequencing FSM that computes res = isqrt(x0) + ... + isqrt(x[N-1]) by
// time-sharing U external isqrt units. The arguments are split into
// B = ceil(N/U) batches: batch k sends x[k*U + j] to unit j for every unit
// whose argument index is still below N (the active set of that batch).
// The next batch is issued only once every active unit of the current batch
// has answered. Responses may come back in any order and with any latency.
// Spurious responses are dropped: from inactive units, repeats from a unit
// that has already answered in this batch, and anything arriving in IDLE.
//
// Parameters
//   N : number of arguments (N >= 1)
//   U : number of isqrt units (1 <= U <= N)
//   W : argument / result width (even, >= 4); roots are W/2 bits wide
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-high reset
//   arg_vld      in   arguments valid, taken only while arg_rdy is high
//   args         in   N*W packed arguments, x[i] = args[i*W +: W]
//   arg_rdy      out  high while idle (combinational)
//   res_vld      out  one-cycle result strobe
//   res          out  W-bit result, held until the next result
//   isqrt_x_vld  out  U per-unit request strobes
//   isqrt_x      out  U*W per-unit operands, unit j at [j*W +: W]
//   isqrt_y_vld  in   U per-unit response strobes
//   isqrt_y      in   U*W/2 per-unit roots, unit j at [j*W/2 +: W/2]

module sum_isqrt_n_fsm #(
    parameter int N = 5,
    parameter int U = 2,
    parameter int W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 arg_vld,
    input  logic [N*W-1:0]       args,
    output logic                 arg_rdy,
    output logic                 res_vld,
    output logic [W-1:0]         res,
    output logic [U-1:0]         isqrt_x_vld,
    output logic [U*W-1:0]       isqrt_x,
    input  logic [U-1:0]         isqrt_y_vld,
    input  logic [U*(W/2)-1:0]   isqrt_y
);

    localparam int RW = W / 2;
    localparam int B  = (N + U - 1) / U;
    localparam int KW = (B > 1) ? $clog2(B) : 1;

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    state_t          state;
    logic [KW-1:0]   batch;
    logic [U-1:0]    done_mask;
    logic [W-1:0]    acc;
    logic [N*W-1:0]  args_q;

    logic [U-1:0]    active;
    logic [U-1:0]    next_active;
    logic [U*W-1:0]  next_x;
    logic [U-1:0]    new_resp;
    logic [W-1:0]    resp_sum;
    logic [W-1:0]    acc_next;
    logic            batch_done;
    logic            last_batch;

    assign arg_rdy = (state == IDLE);

    // Active set of the current batch and of the one after it, plus the
    // operands the following batch will need. Units whose argument index
    // runs past N are left out of the set.
    always_comb begin
        active      = '0;
        next_active = '0;
        next_x      = '0;
        for (int j = 0; j < U; j++) begin
            if (int'(batch) * U + j < N) begin
                active[j] = 1'b1;
            end
            if ((int'(batch) + 1) * U + j < N) begin
                next_active[j]      = 1'b1;
                next_x[j*W +: W]    = args_q[((int'(batch) + 1) * U + j) * W +: W];
            end
        end
    end

    // Only first responses from units still outstanding in this batch count;
    // all of them arriving in the same cycle are summed together.
    always_comb begin
        new_resp = isqrt_y_vld & active & ~done_mask;
        resp_sum = '0;
        for (int j = 0; j < U; j++) begin
            if (new_resp[j]) begin
                resp_sum = resp_sum + {{(W - RW){1'b0}}, isqrt_y[j*RW +: RW]};
            end
        end
    end

    assign acc_next   = acc + resp_sum;
    assign batch_done = (((done_mask | new_resp) & active) == active);
    assign last_batch = (batch == KW'(B - 1));

    // Main sequencer. Batch 0 is issued straight from the incoming args in
    // the acceptance cycle so its request strobes appear one cycle later;
    // later batches are issued from the captured copy the moment the last
    // outstanding response of the previous batch is seen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            batch       <= '0;
            done_mask   <= '0;
            acc         <= '0;
            args_q      <= '0;
            res         <= '0;
            res_vld     <= 1'b0;
            isqrt_x_vld <= '0;
            isqrt_x     <= '0;
        end else begin
            res_vld     <= 1'b0;
            isqrt_x_vld <= '0;
            case (state)
                IDLE: begin
                    if (arg_vld) begin
                        args_q      <= args;
                        acc         <= '0;
                        batch       <= '0;
                        done_mask   <= '0;
                        isqrt_x_vld <= '1;
                        for (int j = 0; j < U; j++) begin
                            isqrt_x[j*W +: W] <= args[j*W +: W];
                        end
                        state       <= WAIT;
                    end
                end
                WAIT: begin
                    if (batch_done) begin
                        done_mask <= '0;
                        if (last_batch) begin
                            res     <= acc_next;
                            res_vld <= 1'b1;
                            acc     <= '0;
                            state   <= IDLE;
                        end else begin
                            acc         <= acc_next;
                            batch       <= batch + 1'b1;
                            isqrt_x_vld <= next_active;
                            for (int j = 0; j < U; j++) begin
                                if (next_active[j]) begin
                                    isqrt_x[j*W +: W] <= next_x[j*W +: W];
                                end
                            end
                        end
                    end else begin
                        done_mask <= done_mask | new_resp;
                        acc       <= acc_next;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sum_isqrt_n_fsm.sv
// tb_sum_isqrt_n_fsm
// ------------------
// Bench for sum_isqrt_n_fsm. Main instance uses N=5, U=2, W=32; a second
// instance with N=U=4 covers the single-batch case. The bench plays the
// isqrt units itself, answering with roots computed by its own reference
// function after a per-unit latency, and optionally injecting duplicate and
// spurious responses. Expected sums and result timing come from the
// argument list and the latencies alone.

module tb_sum_isqrt_n_fsm;

    logic          clk = 1'b0;
    logic          rst = 1'b1;

    // main instance: N=5, U=2
    logic          argVld = 1'b0;
    logic [159:0]  args   = '0;
    logic          argRdy;
    logic          resVld;
    logic [31:0]   res;
    logic [1:0]    xVld;
    logic [63:0]   x;
    logic [1:0]    yVld   = '0;
    logic [31:0]   y      = '0;

    // second instance: N=4, U=4
    logic          argVldB = 1'b0;
    logic [127:0]  argsB   = '0;
    logic          argRdyB;
    logic          resVldB;
    logic [31:0]   resB;
    logic [3:0]    xVldB;
    logic [127:0]  xB;
    logic [3:0]    yVldB   = '0;
    logic [63:0]   yB      = '0;

    int            vectors     = 0;
    int            miscompares = 0;

    int            lat[2];
    bit            noiseMode = 1'b0;
    bit            dupMode   = 1'b0;
    bit            holdMode  = 1'b0;
    bit            chainNext = 1'b0;
    logic [159:0]  chainArgs = '0;

    sum_isqrt_n_fsm #(.N(5), .U(2), .W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .arg_vld     (argVld),
        .args        (args),
        .arg_rdy     (argRdy),
        .res_vld     (resVld),
        .res         (res),
        .isqrt_x_vld (xVld),
        .isqrt_x     (x),
        .isqrt_y_vld (yVld),
        .isqrt_y     (y)
    );

    sum_isqrt_n_fsm #(.N(4), .U(4), .W(32)) dutB (
        .clk         (clk),
        .rst         (rst),
        .arg_vld     (argVldB),
        .args        (argsB),
        .arg_rdy     (argRdyB),
        .res_vld     (resVldB),
        .res         (resB),
        .isqrt_x_vld (xVldB),
        .isqrt_x     (xB),
        .isqrt_y_vld (yVldB),
        .isqrt_y     (yB)
    );

    always #5 clk = ~clk;

    // Hard stop in case something slips past the per-operation cycle budgets.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Floor square root by search over plain arithmetic squares.
    function automatic logic [15:0] isqrtRef(input logic [31:0] v);
        longint r;
        r = 0;
        for (int b = 15; b >= 0; b--) begin
            longint t;
            t = r + (longint'(1) << b);
            if (t * t <= longint'(v)) r = t;
        end
        return r[15:0];
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one operation from its acceptance edge to its result cycle,
    // acting as both isqrt units. Expects arg_vld/args to already be set up
    // in the cycle before the acceptance edge. Returns in the result cycle.
    task automatic runOp(input logic [159:0] a);
        logic [31:0] issued[$];
        int          cnt[2];
        logic [31:0] op[2];
        bit          prevResp[2];
        logic [31:0] expSum;
        int          expCycle;
        int          resCycle;
        logic [1:0]  yv;
        logic [31:0] yval;

        expSum = '0;
        for (int i = 0; i < 5; i++) expSum += {16'h0, isqrtRef(a[i*32 +: 32])};
        expCycle = 1;
        for (int k = 0; k < 3; k++) begin
            int m;
            m = 0;
            for (int j = 0; j < 2; j++)
                if (k * 2 + j < 5 && lat[j] > m) m = lat[j];
            expCycle += m + 1;
        end
        for (int j = 0; j < 2; j++) begin
            cnt[j] = 0;
            op[j] = '0;
            prevResp[j] = 1'b0;
        end
        resCycle = -1;

        @(posedge clk); #1;
        if (holdMode) args = ~a;
        else argVld = 1'b0;
        checkOutput("argRdyBusy", {63'h0, argRdy}, 64'h0);
        checkOutput("singlePulse", {63'h0, resVld}, 64'h0);

        for (int c = 1; c <= 200 && resCycle < 0; c++) begin
            if (c > 1) begin
                @(posedge clk); #1;
            end
            yv = '0;
            yval = '0;
            for (int j = 0; j < 2; j++) begin
                bit prev;
                prev = prevResp[j];
                prevResp[j] = 1'b0;
                if (cnt[j] > 0) begin
                    cnt[j]--;
                    if (cnt[j] == 0) begin
                        yv[j] = 1'b1;
                        yval[j*16 +: 16] = isqrtRef(op[j]);
                        prevResp[j] = 1'b1;
                    end
                end
                if (xVld[j]) begin
                    op[j] = x[j*32 +: 32];
                    cnt[j] = lat[j];
                    issued.push_back(x[j*32 +: 32]);
                end else if (!yv[j] && cnt[j] == 0 && ((dupMode && prev) || noiseMode)) begin
                    yv[j] = 1'b1;
                    yval[j*16 +: 16] = 16'hBEEF;
                end
            end
            yVld = yv;
            y = yval;
            if (resVld) begin
                resCycle = c;
                checkOutput("resValue", {32'h0, res}, {32'h0, expSum});
                if (holdMode) argVld = 1'b0;
                if (chainNext) begin
                    argVld = 1'b1;
                    args = chainArgs;
                end
            end
        end

        checkOutput("resTiming", 64'(resCycle), 64'(expCycle));
        checkOutput("issueCount", 64'(issued.size()), 64'd5);
        for (int i = 0; i < 5 && i < issued.size(); i++)
            checkOutput("issueOperand", {32'h0, issued[i]}, {32'h0, a[i*32 +: 32]});
    endtask

    task automatic applyStimulus(input logic [159:0] a);
        @(posedge clk); #1;
        yVld = '0;
        argVld = 1'b1;
        args = a;
        runOp(a);
    endtask

    function automatic logic [159:0] pack5(input logic [31:0] a0, input logic [31:0] a1,
                                           input logic [31:0] a2, input logic [31:0] a3,
                                           input logic [31:0] a4);
        return {a4, a3, a2, a1, a0};
    endfunction

    initial begin
        logic [159:0] a;
        logic [31:0]  vals[4];

        // reset state
        #2;
        checkOutput("rstResVld", {63'h0, resVld}, 64'h0);
        checkOutput("rstRes", {32'h0, res}, 64'h0);
        checkOutput("rstXVld", {62'h0, xVld}, 64'h0);
        checkOutput("rstX", x, 64'h0);
        checkOutput("rstArgRdy", {63'h0, argRdy}, 64'h1);
        @(posedge clk); #1;
        rst = 1'b0;

        // mixed arguments, unit 1 much slower than unit 0
        lat[0] = 1; lat[1] = 4;
        applyStimulus(pack5(32'd0, 32'd1, 32'd4, 32'hFFFFFFFF, 32'd100));
        checkOutput("sum65548", {32'h0, res}, 64'd65548);

        // out of order, duplicate and spurious responses
        lat[0] = 3; lat[1] = 1;
        dupMode = 1'b1; noiseMode = 1'b1;
        applyStimulus(pack5(32'd16, 32'd9, 32'd25, 32'd49, 32'd81));
        checkOutput("sumNoise", {32'h0, res}, 64'd28);
        dupMode = 1'b0; noiseMode = 1'b0;

        // backpressure during WAIT, then zero-bubble back-to-back accept
        lat[0] = 1; lat[1] = 1;
        holdMode = 1'b1; chainNext = 1'b1;
        chainArgs = pack5(32'd1, 32'd4, 32'd9, 32'd16, 32'd25);
        applyStimulus(pack5(32'd100, 32'd144, 32'd169, 32'd196, 32'd225));
        holdMode = 1'b0; chainNext = 1'b0;
        runOp(chainArgs);
        checkOutput("sumChain", {32'h0, res}, 64'd15);

        // reset in the middle of WAIT, then a late response
        @(posedge clk); #1;
        yVld = '0;
        argVld = 1'b1;
        args = pack5(32'd64, 32'd64, 32'd64, 32'd64, 32'd64);
        @(posedge clk); #1;
        argVld = 1'b0;
        @(posedge clk); #1;
        #2 rst = 1'b1;
        #1;
        checkOutput("abortXVld", {62'h0, xVld}, 64'h0);
        checkOutput("abortX", x, 64'h0);
        checkOutput("abortRes", {32'h0, res}, 64'h0);
        checkOutput("abortArgRdy", {63'h0, argRdy}, 64'h1);
        @(posedge clk); #1;
        rst = 1'b0;
        yVld = 2'b01;
        y = 32'h0000_0008;
        @(posedge clk); #1;
        yVld = '0;
        checkOutput("lateResVld", {63'h0, resVld}, 64'h0);
        @(posedge clk); #1;
        checkOutput("lateResVld2", {63'h0, resVld}, 64'h0);
        checkOutput("lateArgRdy", {63'h0, argRdy}, 64'h1);
        applyStimulus(pack5(32'd36, 32'd49, 32'd64, 32'd81, 32'd99));
        checkOutput("sumAfterAbort", {32'h0, res}, 64'd39);

        // single batch with all four units of the second instance
        vals[0] = 32'd1; vals[1] = 32'd4; vals[2] = 32'd9; vals[3] = 32'd16;
        @(posedge clk); #1;
        argVldB = 1'b1;
        argsB = {vals[3], vals[2], vals[1], vals[0]};
        @(posedge clk); #1;
        argVldB = 1'b0;
        checkOutput("bXVld", {60'h0, xVldB}, 64'hF);
        checkOutput("bXLow", xB[63:0], {vals[1], vals[0]});
        checkOutput("bXHigh", xB[127:64], {vals[3], vals[2]});
        @(posedge clk); #1;
        checkOutput("bEarly", {63'h0, resVldB}, 64'h0);
        yVldB = 4'hF;
        for (int j = 0; j < 4; j++) yB[j*16 +: 16] = isqrtRef(vals[j]);
        @(posedge clk); #1;
        yVldB = '0;
        checkOutput("bResVld", {63'h0, resVldB}, 64'h1);
        checkOutput("bRes", {32'h0, resB}, 64'd10);
        @(posedge clk); #1;
        checkOutput("bPulse", {63'h0, resVldB}, 64'h0);
        checkOutput("bHold", {32'h0, resB}, 64'd10);

        // randomized operations
        for (int n = 0; n < 16; n++) begin
            for (int i = 0; i < 5; i++) begin
                case ($urandom_range(0, 3))
                    0: a[i*32 +: 32] = $urandom_range(0, 300);
                    1: a[i*32 +: 32] = 32'hFFFFFFFF;
                    default: a[i*32 +: 32] = $urandom;
                endcase
            end
            lat[0] = $urandom_range(1, 4);
            lat[1] = $urandom_range(1, 4);
            noiseMode = $urandom_range(0, 1) == 1;
            dupMode = $urandom_range(0, 1) == 1;
            holdMode = $urandom_range(0, 1) == 1;
            applyStimulus(a);
        end
        noiseMode = 1'b0; dupMode = 1'b0; holdMode = 1'b0;
        @(posedge clk); #1;
        yVld = '0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
